// File: rtl/stsystem_tx_scheduler.sv
// Round-robin scheduler that shares one serial transmitter between NREQ clients.
// Each grant sends one frame on txd: start, DATA_W data bits LSB first, parity, stop.
module stsystem_tx_scheduler #(
  parameter int NREQ       = 2,
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                     txclk,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   din,
  output logic [NREQ-1:0]          ack,
  output logic                     txd,
  output logic                     busy,
  output logic [1:0]               gnt_id,
  output logic                     done,
  output logic [3:0]               bit_cnt
);

  localparam int         BITNUM   = DATA_W + 3;
  localparam logic [3:0] LAST_BIT = 4'(BITNUM - 1);
  localparam logic [2:0] NREQ_3   = 3'(NREQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [1:0]        last_gnt;
  logic [1:0]        winner;
  logic              found;
  logic [3:0]        req_pad;
  logic [2:0]        cand;
  logic [DATA_W-1:0] data_sel;
  logic [BITNUM-1:0] shreg;

  // Widen req to four bits so a 2-bit candidate index is always in range.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    req_pad           = '0;
    req_pad[NREQ-1:0] = req;
  end

  // Search last_gnt+1, last_gnt+2, ... modulo NREQ; the first requester seen wins.
  always_comb begin
    winner = last_gnt;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_gnt} + 3'(k);
      if (cand >= NREQ_3) cand = cand - NREQ_3;
      if (!found && req_pad[cand[1:0]]) begin
        found  = 1'b1;
        winner = cand[1:0];
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == 2'(i)) data_sel = din[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge txclk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      gnt_id   <= 2'd0;
      last_gnt <= 2'(NREQ - 1);
      bit_cnt  <= 4'd0;
      shreg    <= '1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_id   <= winner;
            last_gnt <= winner;
          end
        end
        LOAD: begin
          shreg   <= {1'b1, (^data_sel) ^ PARITY_ODD, data_sel, 1'b0};
          bit_cnt <= 4'd0;
        end
        SHIFT: begin
          shreg <= {1'b1, shreg[BITNUM-1:1]};
          // The counter parks on the stop-bit index through GAP and IDLE.
          if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == GAP);
  assign txd  = (state == SHIFT) ? shreg[0] : 1'b1;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = (state == LOAD) && (gnt_id == 2'(i));
    end
  end

endmodule

// File: tb/tb_stsystem_tx_scheduler.sv
// Bench for stsystem_tx_scheduler: a cycle table, directed multi-cycle sequences,
// and random traffic checked against a frame-timeline model.
module tb_stsystem_tx_scheduler;

  localparam int N  = 3;
  localparam int DW = 8;

  logic            txclk = 1'b0;
  logic            clr   = 1'b1;
  logic [N-1:0]    req   = '0;
  logic [N*DW-1:0] din   = '0;
  logic [N-1:0]    ack;
  logic            txd, busy, done;
  logic [1:0]      gnt_id;
  logic [3:0]      bit_cnt;

  logic [1:0]      req_o = '0;
  logic [15:0]     din_o = '0;
  logic [1:0]      ack_o;
  logic            txd_o, busy_o, done_o;
  logic [1:0]      gnt_o;
  logic [3:0]      bc_o;

  stsystem_tx_scheduler #(.NREQ(N), .DATA_W(DW), .PARITY_ODD(1'b0)) u_dut (
    .txclk(txclk), .clr(clr), .req(req), .din(din), .ack(ack), .txd(txd),
    .busy(busy), .gnt_id(gnt_id), .done(done), .bit_cnt(bit_cnt)
  );

  stsystem_tx_scheduler #(.NREQ(2), .DATA_W(DW), .PARITY_ODD(1'b1)) u_odd (
    .txclk(txclk), .clr(clr), .req(req_o), .din(din_o), .ack(ack_o), .txd(txd_o),
    .busy(busy_o), .gnt_id(gnt_o), .done(done_o), .bit_cnt(bc_o)
  );

  always #5 txclk = ~txclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // {ack[2:0], txd, busy, done, gnt_id, bit_cnt}
  function automatic logic [11:0] obs();
    return {ack, txd, busy, done, gnt_id, bit_cnt};
  endfunction

  typedef struct {
    logic [N-1:0]    req;
    logic [N*DW-1:0] din;
    logic [N-1:0]    ack;
    logic            txd;
    logic            busy;
    logic            done;
    logic [3:0]      bit_cnt;
  } vec_t;

  vec_t tbl[15];

  logic [N-1:0] ack_log  [0:63];
  logic [1:0]   gnt_log  [0:63];
  logic         txd_log  [0:63];
  logic         done_log [0:63];
  logic         txdo_log [0:63];
  logic         doneo_log[0:63];

  // Runs n cycles from a negedge, logging outputs; optionally drops each req on its ack.
  task automatic run(input int base, input int n, input bit drop);
    for (int c = 0; c < n; c++) begin
      #1;
      ack_log[base+c]   = ack;
      gnt_log[base+c]   = gnt_id;
      txd_log[base+c]   = txd;
      done_log[base+c]  = done;
      txdo_log[base+c]  = txd_o;
      doneo_log[base+c] = done_o;
      if (drop) begin
        req   = req & ~ack;
        req_o = req_o & ~ack_o;
      end
      @(posedge txclk);
      @(negedge txclk);
    end
  endtask

  function automatic logic [10:0] line_at(input int s, input bit odd);
    logic [10:0] r;
    for (int j = 0; j < 11; j++) r[j] = odd ? txdo_log[s+j] : txd_log[s+j];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge txclk);
    clr   = 1'b1;
    req   = '0;
    req_o = '0;
    #1;
    check("reset_state", obs(), 12'h100);
    check("reset_state_odd", {ack_o, txd_o, busy_o, done_o, gnt_o, bc_o}, 11'h100);
    @(negedge txclk);
    clr = 1'b0;
  endtask

  // Reference model: where the scheduler is within a frame timeline.
  // pos -1 = idle, 0 = ack cycle, 1..11 = line bits, 12 = done cycle.
  int          m_pos, m_gnt, m_last, m_bc;
  logic [10:0] m_frame;

  task automatic m_reset();
    m_pos = -1; m_gnt = 0; m_last = N - 1; m_bc = 0; m_frame = '1;
  endtask

  function automatic logic [11:0] m_exp();
    logic [N-1:0] a;
    logic         t;
    a = (m_pos == 0) ? N'(1 << m_gnt) : '0;
    t = (m_pos >= 1 && m_pos <= 11) ? m_frame[m_pos-1] : 1'b1;
    return {a, t, m_pos >= 0, m_pos == 12, 2'(m_gnt), 4'(m_bc)};
  endfunction

  task automatic m_step(input logic [N-1:0] r, input logic [N*DW-1:0] d);
    logic [DW-1:0] data;
    bit            got;
    if (m_pos == -1) begin
      got = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (!got && r[idx]) begin
          got = 1'b1; m_gnt = idx; m_last = idx; m_pos = 0;
        end
      end
    end else if (m_pos == 0) begin
      data    = d[m_gnt*DW +: DW];
      m_frame = {1'b1, ^data, data, 1'b0};
      m_pos   = 1;
      m_bc    = 0;
    end else if (m_pos <= 11) begin
      m_pos++;
      if (m_pos <= 11) m_bc = m_pos - 1;
    end else begin
      m_pos = -1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0]  a5_line;
    logic [11:0]  e;
    a5_line = 11'b1_0_1010_0101_0;
    for (int c = 0; c < 15; c++) begin
      tbl[c].req     = (c == 0) ? 3'b001 : 3'b000;
      tbl[c].din     = 24'h0000A5;
      tbl[c].ack     = (c == 1) ? 3'b001 : 3'b000;
      tbl[c].txd     = (c >= 2 && c <= 12) ? a5_line[c-2] : 1'b1;
      tbl[c].busy    = (c >= 1 && c <= 13);
      tbl[c].done    = (c == 13);
      tbl[c].bit_cnt = (c <= 2) ? 4'd0 : (c <= 12) ? 4'(c - 2) : 4'd10;
    end

    // Single frame, table driven
    do_reset();
    for (int c = 0; c < 15; c++) begin
      req = tbl[c].req;
      din = tbl[c].din;
      #1;
      check($sformatf("table_c%0d", c), obs(),
            {tbl[c].ack, tbl[c].txd, tbl[c].busy, tbl[c].done, 2'b00, tbl[c].bit_cnt});
      @(posedge txclk);
      @(negedge txclk);
    end

    // Contention: req0 and req1 together, each dropped on its ack
    do_reset();
    din = 24'h00FF00;
    req = 3'b011;
    run(0, 30, 1'b1);
    check("cont_ack0", ack_log[1], 3'b001);
    check("cont_gnt0", gnt_log[1], 2'd0);
    check("cont_line0", line_at(2, 0), 11'b1_0_00000000_0);
    check("cont_done0", done_log[13], 1'b1);
    check("cont_ack1", ack_log[15], 3'b010);
    check("cont_gnt1", gnt_log[15], 2'd1);
    check("cont_line1", line_at(16, 0), 11'b1_0_11111111_0);
    check("cont_done1", done_log[27], 1'b1);
    check("cont_quiet", ack_log[29], 3'b000);

    // Fairness: both held for four frames
    do_reset();
    din = 24'h003355;
    req = 3'b011;
    run(0, 56, 1'b0);
    check("fair_f0", ack_log[1],  3'b001);
    check("fair_f1", ack_log[15], 3'b010);
    check("fair_f2", ack_log[29], 3'b001);
    check("fair_f3", ack_log[43], 3'b010);

    // Single requester back to back, no penalty
    do_reset();
    req = 3'b001;
    run(0, 30, 1'b0);
    check("b2b_f0", ack_log[1],  3'b001);
    check("b2b_f1", ack_log[15], 3'b001);
    check("b2b_f2", ack_log[29], 3'b001);

    // Late req1 arriving mid-frame is granted next
    do_reset();
    req = 3'b001;
    run(0, 5, 1'b0);
    req = 3'b011;
    run(5, 25, 1'b0);
    check("late_f0", ack_log[1],  3'b001);
    check("late_f1", ack_log[15], 3'b010);
    check("late_f2", ack_log[29], 3'b001);

    // Parity: odd with 0x00, even with 0x01
    do_reset();
    din   = 24'h000001;
    din_o = 16'h0000;
    req   = 3'b001;
    req_o = 2'b01;
    run(0, 15, 1'b1);
    check("par_even_bit", txd_log[11], 1'b1);
    check("par_even_line", line_at(2, 0), 11'b1_1_00000001_0);
    check("par_odd_bit", txdo_log[11], 1'b1);
    check("par_odd_line", line_at(2, 1), 11'b1_1_00000000_0);
    check("par_odd_done", doneo_log[13], 1'b1);

    // Reset mid-frame
    do_reset();
    din = 24'h00003C;
    req = 3'b001;
    run(0, 7, 1'b0);
    #1;
    check("mid_bitcnt", {busy, bit_cnt}, {1'b1, 4'd5});
    clr = 1'b1;
    #1;
    check("mid_clr_now", {ack, txd, busy, done}, 6'b000100);
    for (int c = 0; c < 2; c++) begin
      @(posedge txclk);
      @(negedge txclk);
      #1;
      check("mid_clr_hold", {ack, txd, busy, done}, 6'b000100);
    end
    clr = 1'b0;
    req = 3'b011;
    run(0, 15, 1'b1);
    check("mid_ack0", ack_log[1], 3'b001);
    check("mid_gnt0", gnt_log[1], 2'd0);
    check("mid_line", line_at(2, 0), 11'b1_0_00111100_0);
    check("mid_done", done_log[13], 1'b1);

    // Idle line
    do_reset();
    req = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("idle", {ack, txd, busy, done}, 6'b000100);
      @(posedge txclk);
      @(negedge txclk);
    end

    // Random traffic against the model
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        clr = 1'b1;
        m_reset();
        #1;
        check("rand_clr", obs(), m_exp());
        @(posedge txclk);
        @(negedge txclk);
        clr = 1'b0;
        continue;
      end
      #1;
      e = m_exp();
      check("rand", obs(), e);
      for (int i = 0; i < N; i++) begin
        if (e[9+i])             req[i] = 1'($urandom_range(0, 1));
        else if (!req[i])       req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
      din = 24'($urandom());
      m_step(req, din);
      @(posedge txclk);
      @(negedge txclk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stsystem_tx_scheduler.md
Name: stsystem_tx_scheduler

Overview:
Shares the serial transmitter between NREQ requesters using round-robin arbitration. It captures the granted requester's byte and frames it as start, data LSB-first, parity and stop. It sequences the 11-bit serial shift with an internal bit counter and reports completion. It sits between the client blocks and the serial line, and drives the line directly on txclk, which is the bit clock.

Parameters:
NREQ, 2, number of requesters; legal range 2..4.
DATA_W, 8, data bits per frame; frame length BITNUM = DATA_W+3 = 11 (localparam).
PARITY_ODD, 0, parity select: 0 = even parity, 1 = odd parity.

Ports:
txclk  in  1  bit clock; all state changes on its rising edge.
clr  in  1  asynchronous reset, active-high.
req  in  NREQ  request per requester; level, held until the matching ack.
din  in  NREQ*DATA_W  packed data; requester i occupies [i*DATA_W +: DATA_W].
ack  out  NREQ  one-hot, one-cycle pulse when the grantee's din is captured.
txd  out  1  serial line; idles high.
busy  out  1  high whenever the state is not IDLE.
gnt_id  out  2  index of the current or most recent grantee.
done  out  1  one-cycle pulse after the stop bit has been sent.
bit_cnt  out  4  current bit index 0..BITNUM-1 (debug).

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, txd=1, busy=0, ack=0, done=0, gnt_id=0, bit_cnt=0, shift register all ones, last_gnt=NREQ-1 (so requester 0 wins first).
- Reset mid-frame: the frame is abandoned immediately and txd returns to 1. No done pulse is generated. Arbitration restarts from its reset state.
- FSM states: IDLE -> LOAD -> SHIFT -> GAP -> IDLE. All outputs are registered or decoded from state only.
- IDLE: txd=1. req is sampled only in this state.
  - If any req bit is high, select the winner in order last_gnt+1, last_gnt+2, ... modulo NREQ.
  - Register the winner into gnt_id and last_gnt, then go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD (1 cycle): ack[gnt_id]=1; all other ack bits are 0.
  - Shift register <= {1'b1, parity, din[gnt_id], 1'b0}, LSB first.
  - parity = (^data) ^ PARITY_ODD.
  - bit_cnt <= 0. Go to SHIFT.
- SHIFT (BITNUM cycles): txd = shreg[0].
  - Each cycle, the shift register shifts right with 1 filled in, and bit_cnt increments.
  - In the cycle with bit_cnt == BITNUM-1 (stop bit on the line), the next state is GAP.
- GAP (1 cycle): txd=1, done=1. Go to IDLE. bit_cnt holds BITNUM-1 until the next LOAD.
- Timing with req asserted while in IDLE at cycle 0:
  - ack in cycle 1.
  - Start bit on txd in cycle 2; stop bit in cycle 12.
  - done in cycle 13; back in IDLE in cycle 14.
  - Minimum frame period is 14 cycles.
- Requests during a busy frame are ignored until IDLE. A req still high in IDLE after its ack counts as a new request.
- A requester that drops req before it is granted loses nothing; it is simply not considered.
- din only has to be stable in the LOAD cycle.
- A single active requester is granted back-to-back with no penalty. With all requesters active, grants rotate strictly.
- gnt_id is stable from the cycle after IDLE arbitration until the next grant.
- busy = (state != IDLE).

Test Plan:
- Single frame: req0=1 with din0=8'hA5, PARITY_ODD=0 -> ack[0] in cycle 1; txd in cycles 2-12 = 0,1,0,1,0,0,1,0,1,0,1; done in cycle 13; busy high in cycles 1-13.
- Contention: req0 and req1 both asserted in cycle 0, din0=8'h00, din1=8'hFF, each req dropped on its ack -> ack[0] in cycle 1 and ack[1] in cycle 15. Frame 2 data bits are all 1 with parity 0; gnt_id reads 0 then 1.
- Fairness: req0 and req1 held high for 4 frames -> grant order 0,1,0,1. A late req1, asserted mid-frame of a req0 frame and held, is granted next.
- Odd parity: PARITY_ODD=1, din0=8'h00 -> parity bit 1. With PARITY_ODD=0 and din0=8'h01 -> parity bit 1.
- Reset mid-frame: assert clr during bit_cnt=5 -> txd=1, busy=0, ack=0 immediately; no done pulse. After release with req1 and req0 both held, requester 0 is granted first and sends a complete frame.
- Idle line: no req for 20 cycles -> txd=1, busy=0, ack=0, done=0 throughout.
